// File: rtl/fifo_param_flags.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky error flags and a registered read path.
module fifo_param_flags #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] FIFO_data_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] alto,
    input  logic [ADDR_WIDTH-1:0] bajo,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] FIFO_data_out,
    output logic                  valid_out,
    output logic                  wr_enable,
    output logic                  rd_enable,
    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    // Flags come straight from the registered count so threshold changes act immediately
    assign full_fifo         = (count == DEPTH_CNT);
    assign empty_fifo        = (count == '0);
    assign almost_full_fifo  = (count >= (DEPTH_CNT - {1'b0, alto}));
    assign almost_empty_fifo = (count <= {1'b0, bajo});

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push
    assign rd_enable = pop & ~empty_fifo;
    assign wr_enable = push & (~full_fifo | rd_enable);

    always_ff @(posedge clk) begin
        if (wr_enable) begin
            mem[wr_ptr] <= FIFO_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            FIFO_data_out <= '0;
            valid_out     <= 1'b0;
        end else begin
            valid_out <= rd_enable;
            if (wr_enable) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_enable) begin
                FIFO_data_out <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({wr_enable, rd_enable})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A fresh error in the same cycle as err_clear keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~err_clear) | (push & ~wr_enable);
            underflow <= (underflow & ~err_clear) | (pop  & ~rd_enable);
        end
    end

endmodule

// File: tb/tb_fifo_param_flags.sv
// Directed self-checking bench for fifo_param_flags (DATA_WIDTH=10, DEPTH=8).
module tb_fifo_param_flags;

    localparam int DW = 10;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] FIFO_data_in;
    logic          push;
    logic          pop;
    logic [AW-1:0] alto;
    logic [AW-1:0] bajo;
    logic          err_clear;
    logic [DW-1:0] FIFO_data_out;
    logic          valid_out;
    logic          wr_enable;
    logic          rd_enable;
    logic          full_fifo;
    logic          empty_fifo;
    logic          almost_full_fifo;
    logic          almost_empty_fifo;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int testsRun    = 0;
    int testsFailed = 0;

    fifo_param_flags #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .FIFO_data_in      (FIFO_data_in),
        .push              (push),
        .pop               (pop),
        .alto              (alto),
        .bajo              (bajo),
        .err_clear         (err_clear),
        .FIFO_data_out     (FIFO_data_out),
        .valid_out         (valid_out),
        .wr_enable         (wr_enable),
        .rd_enable         (rd_enable),
        .full_fifo         (full_fifo),
        .empty_fifo        (empty_fifo),
        .almost_full_fifo  (almost_full_fifo),
        .almost_empty_fifo (almost_empty_fifo),
        .count             (count),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge, where inputs are changed
    task automatic applyStimulus(input logic p, input logic q, input logic [DW-1:0] d);
        push         = p;
        pop          = q;
        FIFO_data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin : stim
        logic [DW-1:0] model[$];
        logic [DW-1:0] expData;
        logic [DW-1:0] ramp;
        int            maxCount;

        reset = 1'b1; push = 1'b0; pop = 1'b0; FIFO_data_in = '0;
        alto = 3'd2; bajo = 3'd1; err_clear = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        checkOutput("rst_empty",    32'(empty_fifo),        32'd1);
        checkOutput("rst_aempty",   32'(almost_empty_fifo), 32'd1);
        checkOutput("rst_full",     32'(full_fifo),         32'd0);
        checkOutput("rst_afull",    32'(almost_full_fifo),  32'd0);
        checkOutput("rst_count",    32'(count),             32'd0);
        checkOutput("rst_overflow", 32'(overflow),          32'd0);
        checkOutput("rst_underflow",32'(underflow),         32'd0);
        checkOutput("rst_valid",    32'(valid_out),         32'd0);

        // Fill to full, watching the thresholds (alto=2 -> afull at 6, bajo=1)
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, DW'(i));
            checkOutput("fill_count",  32'(count),             32'(i));
            checkOutput("fill_aempty", 32'(almost_empty_fifo), 32'(i <= 1));
            checkOutput("fill_afull",  32'(almost_full_fifo),  32'(i >= 6));
            checkOutput("fill_full",   32'(full_fifo),         32'(i == 8));
        end
        push = 1'b1; FIFO_data_in = 10'h2AA; #1;
        checkOutput("ovf_wr_en", 32'(wr_enable), 32'd0);
        applyStimulus(1'b1, 1'b0, 10'h2AA);
        checkOutput("ovf_flag",  32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(count),    32'd8);

        // Simultaneous push and pop on a full FIFO
        push = 1'b1; pop = 1'b1; FIFO_data_in = 10'h3FF; #1;
        checkOutput("fullpp_wr_en", 32'(wr_enable), 32'd1);
        checkOutput("fullpp_rd_en", 32'(rd_enable), 32'd1);
        applyStimulus(1'b1, 1'b1, 10'h3FF);
        checkOutput("fullpp_count", 32'(count),         32'd8);
        checkOutput("fullpp_valid", 32'(valid_out),     32'd1);
        checkOutput("fullpp_data",  32'(FIFO_data_out), 32'h001);
        for (int i = 2; i <= 9; i++) begin
            expData = (i == 9) ? 10'h3FF : DW'(i);
            applyStimulus(1'b0, 1'b1, '0);
            checkOutput("drain_valid", 32'(valid_out),     32'd1);
            checkOutput("drain_data",  32'(FIFO_data_out), 32'(expData));
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("drain_idle_valid", 32'(valid_out),     32'd0);
        checkOutput("drain_hold_data",  32'(FIFO_data_out), 32'h3FF);
        checkOutput("drain_empty",      32'(empty_fifo),    32'd1);

        // Push and pop together on empty
        push = 1'b1; pop = 1'b1; FIFO_data_in = 10'h155; #1;
        checkOutput("emptypp_rd_en", 32'(rd_enable), 32'd0);
        checkOutput("emptypp_wr_en", 32'(wr_enable), 32'd1);
        applyStimulus(1'b1, 1'b1, 10'h155);
        checkOutput("emptypp_underflow", 32'(underflow), 32'd1);
        checkOutput("emptypp_count",     32'(count),     32'd1);
        checkOutput("emptypp_valid",     32'(valid_out), 32'd0);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("emptypp_data",  32'(FIFO_data_out), 32'h155);
        checkOutput("emptypp_valid2",32'(valid_out),     32'd1);

        // Clear errors: both flags drop the next cycle
        err_clear = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        err_clear = 1'b0;
        checkOutput("clr_overflow",  32'(overflow),  32'd0);
        checkOutput("clr_underflow", 32'(underflow), 32'd0);

        // Wrap-around: two rounds of 5 pushes then 5 pops, ramp data
        ramp = '0;
        maxCount = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                model.push_back(ramp);
                applyStimulus(1'b1, 1'b0, ramp);
                ramp = ramp + 1'b1;
                if (int'(count) > maxCount) maxCount = int'(count);
            end
            for (int k = 0; k < 5; k++) begin
                applyStimulus(1'b0, 1'b1, '0);
                expData = model.pop_front();
                checkOutput("wrap_data",  32'(FIFO_data_out), 32'(expData));
                checkOutput("wrap_valid", 32'(valid_out),     32'd1);
            end
        end
        checkOutput("wrap_max_count", 32'(maxCount),  32'd5);
        checkOutput("wrap_overflow",  32'(overflow),  32'd0);
        checkOutput("wrap_underflow", 32'(underflow), 32'd0);

        // err_clear together with a rejected pop keeps underflow set
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("err_set_underflow", 32'(underflow), 32'd1);
        err_clear = 1'b1;
        applyStimulus(1'b0, 1'b1, '0);
        err_clear = 1'b0;
        checkOutput("err_clear_race", 32'(underflow), 32'd1);

        // Live threshold changes at count 4
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, DW'(10'h100 + k));
        checkOutput("thr_count", 32'(count), 32'd4);
        alto = 3'd4; #1;
        checkOutput("thr_afull_on",  32'(almost_full_fifo),  32'd1);
        alto = 3'd2; bajo = 3'd4; #1;
        checkOutput("thr_afull_off", 32'(almost_full_fifo),  32'd0);
        checkOutput("thr_aempty_on", 32'(almost_empty_fifo), 32'd1);
        bajo = 3'd3; #1;
        checkOutput("thr_aempty_off",32'(almost_empty_fifo), 32'd0);
        bajo = 3'd1;

        // Reset mid-stream discards data; next pop is rejected
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        reset = 1'b0;
        checkOutput("midrst_count",    32'(count),      32'd0);
        checkOutput("midrst_empty",    32'(empty_fifo), 32'd1);
        checkOutput("midrst_underflow",32'(underflow),  32'd0);
        pop = 1'b1; #1;
        checkOutput("midrst_rd_en", 32'(rd_enable), 32'd0);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("midrst_valid",     32'(valid_out), 32'd0);
        checkOutput("midrst_underflow2",32'(underflow), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
